uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART transmitter between NUM_REQ byte-stream requesters, for example the AXI response framer and the status/event reporter. Each grant is frame-locked: once a requester wins, it keeps the transmitter until its byte flagged last has completed on the line. The block sits directly in front of the 8N1 transmitter. It drives tx_data/tx_start and sequences on tx_busy/tx_done. An optional inter-frame idle gap is inserted between frames.

---
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-locked round-robin arbiter in front of an 8N1 UART transmitter
// Optional mid-frame stall abort: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int GW = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [GW-1:0]        grant_id,
  output logic                 frame_active,
  output logic                 frame_done,
  output logic                 err_timeout
);

  typedef enum logic [2:0] {
    S_ARB   = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [31:0] GAP_LAST = 32'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [31:0]   gap_cnt;
  logic          last_q;

  logic          arb_hit;
  logic [GW-1:0] arb_idx;
  logic          sel_valid;
  logic [7:0]    sel_data;
  logic          sel_last;
  logic [GW-1:0] next_ptr;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [31:0] STALL_LAST = 32'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  logic        first_q;
  logic [31:0] stall_cnt;
`endif

  // Round-robin scan: first valid requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    arb_hit = 1'b0;
    arb_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!arb_hit && req_valid[idx]) begin
        arb_hit = 1'b1;
        arb_idx = GW'(idx);
      end
    end
  end

  // Mux the granted requester's byte stream and decode its ready strobe.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid    = req_valid[i];
        sel_data     = req_data[i*8 +: 8];
        sel_last     = req_last[i];
        req_ready[i] = (state == S_FETCH);
      end
    end
  end

  // The winner of a finished frame drops to lowest priority.
  assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // tx_start is gated by tx_busy so it can never overlap a transmission.
  assign tx_start     = (state == S_ISSUE) && !tx_busy;
  assign frame_active = (state != S_ARB) && (state != S_GAP);

  // Main sequencer: grant, fetch byte, hand to transmitter, await completion, idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ARB;
      rr_ptr      <= '0;
      gap_cnt     <= '0;
      grant_id    <= '0;
      tx_data     <= 8'h00;
      last_q      <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      first_q     <= 1'b0;
      stall_cnt   <= '0;
`endif
    end else begin
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_ARB: begin
          if (arb_hit) begin
            grant_id <= arb_idx;
            state    <= S_FETCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
            first_q   <= 1'b1;
            stall_cnt <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (sel_valid) begin
            tx_data <= sel_data;
            last_q  <= sel_last;
            state   <= S_ISSUE;
`ifdef UART_TX_ARB_TIMEOUT_EN
            first_q   <= 1'b0;
            stall_cnt <= '0;
          end else if (!first_q) begin
            if (stall_cnt == STALL_LAST) begin
              err_timeout <= 1'b1;
              rr_ptr      <= next_ptr;
              stall_cnt   <= '0;
              gap_cnt     <= '0;
              state       <= (GAP_CYCLES == 0) ? S_ARB : S_GAP;
            end else begin
              stall_cnt <= stall_cnt + 32'd1;
            end
`endif
          end
        end
        S_ISSUE: begin
          if (tx_busy) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            if (last_q) begin
              frame_done <= 1'b1;
              rr_ptr     <= next_ptr;
              gap_cnt    <= '0;
              state      <= (GAP_CYCLES == 0) ? S_ARB : S_GAP;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= S_ARB;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        default: state <= S_ARB;
      endcase
    end
  end

endmodule
